// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit bundle: ID/EX/MEM hazard inputs and pipeline-register controls.
// HAZARD_PERF_EN adds the three performance counter outputs.
interface hazard_unit_if;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        ex_mem_read;
    logic [4:0]  ex_rd_addr;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ack;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_write;
    logic        idex_bubble;
    logic        exmem_write;
    logic        memwb_bubble;
    logic        mem_err;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_stall;
    logic [31:0] perf_mem_wait;
    logic [31:0] perf_flush;
`endif

    modport master (
        output id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
        output ex_mem_read, ex_rd_addr, ex_branch_taken, mem_req, mem_ack,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
        input  exmem_write, memwb_bubble, mem_err
`ifdef HAZARD_PERF_EN
        , input perf_lu_stall, perf_mem_wait, perf_flush
`endif
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
        input  ex_mem_read, ex_rd_addr, ex_branch_taken, mem_req, mem_ack,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
        output exmem_write, memwb_bubble, mem_err
`ifdef HAZARD_PERF_EN
        , output perf_lu_stall, perf_mem_wait, perf_flush
`endif
    );
endinterface

// File: rtl/hazard_unit.sv
// Stall/bubble/flush controller for the 5-stage RV32I pipeline with a MEM wait watchdog.
// Optional HAZARD_PERF_EN adds wrapping 32-bit load-use, memory-wait and flush counters.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] CNT_MAX   = {TO_W{1'b1}};
    localparam logic [TO_W-1:0] CNT_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] CNT_ZERO  = {TO_W{1'b0}};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TO_W-1:0] r_cnt;
    logic [TO_W-1:0] w_cnt_nxt;
    logic            r_mem_err;
    logic            w_mem_err_nxt;

    logic w_lu;
    logic w_frz;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_case_br;
    logic w_case_lu;

    assign w_rs1_hit = bus.id_use_rs1 && (bus.id_rs1_addr == bus.ex_rd_addr);
    assign w_rs2_hit = bus.id_use_rs2 && (bus.id_rs2_addr == bus.ex_rd_addr);
    assign w_lu      = bus.ex_mem_read && (bus.ex_rd_addr != 5'd0) && (w_rs1_hit || w_rs2_hit);
    assign w_frz     = (bus.mem_req && !bus.mem_ack) || (r_state == ST_ERR);
    assign w_case_br = !w_frz && bus.ex_branch_taken;
    assign w_case_lu = !w_frz && !bus.ex_branch_taken && w_lu;

    // State, wait counter and sticky error register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_cnt     <= CNT_ZERO;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mem_err <= w_mem_err_nxt;
        end
    end

    // Next-state, watchdog counter and error flag
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_mem_err_nxt = r_mem_err;
        case (r_state)
            ST_RUN: begin
                if (bus.mem_req && !bus.mem_ack) begin
                    w_state_nxt = ST_MEM_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            ST_MEM_WAIT: begin
                // Ack and abort both release the wait; only a held request can time out
                if (bus.mem_ack || !bus.mem_req) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = CNT_ZERO;
                end else if ((MEM_TIMEOUT != 0) && (r_cnt == TIMEOUT_C)) begin
                    w_state_nxt   = ST_ERR;
                    w_mem_err_nxt = 1'b1;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_ERR: begin
                w_state_nxt   = ST_ERR;
                w_mem_err_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Pipeline register controls in priority order: reset, freeze, branch, load-use
    always_comb begin
        bus.pc_write     = 1'b1;
        bus.ifid_write   = 1'b1;
        bus.ifid_flush   = 1'b0;
        bus.idex_write   = 1'b1;
        bus.idex_bubble  = 1'b0;
        bus.exmem_write  = 1'b1;
        bus.memwb_bubble = 1'b0;
        if (rst) begin
            bus.pc_write     = 1'b0;
            bus.ifid_write   = 1'b0;
            bus.ifid_flush   = 1'b1;
            bus.idex_write   = 1'b0;
            bus.idex_bubble  = 1'b1;
            bus.exmem_write  = 1'b0;
            bus.memwb_bubble = 1'b1;
        end else if (w_frz) begin
            bus.pc_write     = 1'b0;
            bus.ifid_write   = 1'b0;
            bus.idex_write   = 1'b0;
            bus.exmem_write  = 1'b0;
            bus.memwb_bubble = 1'b1;
        end else if (w_case_br) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
        end else if (w_case_lu) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_bubble = 1'b1;
        end else begin
            bus.pc_write = 1'b1;
        end
    end

    assign bus.mem_err = r_mem_err;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_mw;
    logic [31:0] r_perf_fl;

    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_lu <= 32'd0;
            r_perf_mw <= 32'd0;
            r_perf_fl <= 32'd0;
        end else begin
            r_perf_lu <= r_perf_lu + {31'd0, w_case_lu};
            r_perf_mw <= r_perf_mw + {31'd0, w_frz};
            r_perf_fl <= r_perf_fl + {31'd0, w_case_br};
        end
    end

    assign bus.perf_lu_stall = r_perf_lu;
    assign bus.perf_mem_wait = r_perf_mw;
    assign bus.perf_flush    = r_perf_fl;
`endif

endmodule
